// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types, constants and helpers for the BCD serial subtractor
//   BCD_DIGIT_W     width of one packed BCD digit
//   BCD_NINE        constant used to form the 9's complement of a digit
//   bcd_digit_t     one BCD digit
//   bcd_sub_state_e subtractor FSM states
//   bcd_digit_ok()  true when a digit is a legal BCD value (0..9)
package bcd_pkg;
    localparam int BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_NINE = 4'd9;
    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;
    typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} bcd_sub_state_e;
    function automatic logic bcd_digit_ok(input bcd_digit_t d);
        return d <= BCD_NINE;
    endfunction
endpackage

// File: rtl/bcd_digit_adder.sv
// bcd_digit_adder: combinational single-digit BCD adder with decimal correction
//   a_i, b_i  BCD addend digits
//   c_i       carry in
//   d_o       BCD sum digit
//   c_o       decimal carry out
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  bcd_digit_t a_i,
    input  bcd_digit_t b_i,
    input  logic       c_i,
    output bcd_digit_t d_o,
    output logic       c_o
);
    logic [BCD_DIGIT_W:0] s;
    // Largest sum is 9 + 9 + 1 = 19, so one subtraction of 10 always suffices.
    assign s   = {1'b0, a_i} + {1'b0, b_i} + {{BCD_DIGIT_W{1'b0}}, c_i};
    assign c_o = s > 5'd9;
    assign d_o = c_o ? BCD_DIGIT_W'(s - 5'd10) : s[BCD_DIGIT_W-1:0];
endmodule

// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor: digit-serial BCD A - B via 10's complement, sign-magnitude result
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operand handshake (ready only in IDLE)
//   a_bcd, b_bcd         packed BCD operands, digit 0 in bits [3:0]
//   out_valid, out_ready result handshake (valid only in DONE)
//   diff_bcd             magnitude of A - B
//   neg                  result is negative
//   err                  an operand digit was above 9
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a_bcd,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b_bcd,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] diff_bcd,
    output logic                        neg,
    output logic                        err
);
    localparam int W  = BCD_DIGIT_W * DIGITS;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    bcd_sub_state_e state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, r_q, r_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d, neg_q, neg_d, err_q, err_d;
    logic           bad, last, co;
    bcd_digit_t     x, y, d;

    // SUB adds a_i + (9 - b_i); NEG reuses the same adder for 0 + (9 - r_i).
    // Operands and result shift right one digit per step, so digit 0 is always current.
    assign x = state_q == SUB ? a_q[BCD_DIGIT_W-1:0] : '0;
    assign y = BCD_NINE - (state_q == SUB ? b_q[BCD_DIGIT_W-1:0] : r_q[BCD_DIGIT_W-1:0]);

    bcd_digit_adder u_add (
        .a_i(x),
        .b_i(y),
        .c_i(carry_q),
        .d_o(d),
        .c_o(co)
    );

    assign last = idx_q == IW'(DIGITS - 1);

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            bad = bad | !bcd_digit_ok(a_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W])
                      | !bcd_digit_ok(b_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        neg_d   = neg_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a_bcd;
                b_d     = b_bcd;
                r_d     = '0;
                idx_d   = '0;
                carry_d = 1'b1;
                neg_d   = 1'b0;
                err_d   = bad;
                state_d = bad ? DONE : SUB;
            end
            SUB, NEG: begin
                a_d     = a_q >> BCD_DIGIT_W;
                b_d     = b_q >> BCD_DIGIT_W;
                r_d     = (r_q >> BCD_DIGIT_W) | (W'(d) << (W - BCD_DIGIT_W));
                carry_d = co;
                idx_d   = idx_q + 1'b1;
                if (last) begin
                    idx_d = '0;
                    // A final carry of 0 after SUB means A < B: negate the 10's-complement result.
                    if (state_q == SUB && !co) begin
                        state_d = NEG;
                        carry_d = 1'b1;
                    end else begin
                        state_d = DONE;
                        neg_d   = state_q == NEG;
                    end
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign diff_bcd  = r_q;
    assign neg       = neg_q;
    assign err       = err_q;
endmodule
